// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - shared types and helpers for the convolution stripe sequencer
package conv_seq_pkg;

  localparam int N_BANKS = 3;
  localparam int PIX_W   = 8;
  localparam int RES_W   = 13;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_WAIT_RES = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  function automatic logic [1:0] inc_mod3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

endpackage

// File: rtl/conv_bank_rot.sv
// rtl/conv_bank_rot.sv - row-bank rotation pointers, loaded-row count and column reorder
module conv_bank_rot #(
  parameter int PIX_W = conv_seq_pkg::PIX_W
) (
  input  logic               i_CLK,
  input  logic               i_rst,
  input  logic               wrap_i,
  output logic [1:0]         wr_bank_o,
  output logic               rows_full_o,
  input  logic [3*PIX_W-1:0] rd_data_i,
  output logic [3*PIX_W-1:0] col_data_o
);
  import conv_seq_pkg::*;

  logic [1:0] wr_bank_q;
  logic [1:0] newest_q;
  logic [1:0] rows_q;

  always_ff @(posedge i_CLK) begin
    if (i_rst) begin
      wr_bank_q <= 2'd0;
      newest_q  <= 2'd2;
      rows_q    <= 2'd0;
    end else if (wrap_i) begin
      newest_q  <= wr_bank_q;
      wr_bank_q <= inc_mod3(wr_bank_q);
      if (rows_q != 2'(N_BANKS)) rows_q <= rows_q + 2'd1;
    end
  end

  function automatic logic [PIX_W-1:0] pick(input logic [1:0] b, input logic [3*PIX_W-1:0] d);
    case (b)
      2'd0:    return d[PIX_W-1:0];
      2'd1:    return d[2*PIX_W-1:PIX_W];
      default: return d[3*PIX_W-1:2*PIX_W];
    endcase
  endfunction

  // Oldest row on top, newest row at the bottom.
  assign col_data_o  = {pick(inc_mod3(newest_q), rd_data_i),
                        pick(inc_mod3(inc_mod3(newest_q)), rd_data_i),
                        pick(newest_q, rd_data_i)};
  assign wr_bank_o   = wr_bank_q;
  assign rows_full_o = (rows_q == 2'(N_BANKS));

endmodule

// File: rtl/conv_stripe_sequencer.sv
// rtl/conv_stripe_sequencer.sv - loads row banks and sequences one output row through the 3x3 unit
module conv_stripe_sequencer #(
  parameter int ADDR_W = 10,
  parameter int PIX_W  = conv_seq_pkg::PIX_W,
  parameter int RES_W  = conv_seq_pkg::RES_W
) (
  input  logic               i_CLK,
  input  logic               i_rst,
  input  logic [ADDR_W-1:0]  i_img_length,
  input  logic               i_load,
  input  logic               i_run,
  input  logic               i_valid,
  input  logic [PIX_W-1:0]   i_pixel,
  output logic [2:0]         o_wr_en,
  output logic [ADDR_W-1:0]  o_wr_addr,
  output logic [PIX_W-1:0]   o_wr_data,
  output logic               o_rd_en,
  output logic [ADDR_W-1:0]  o_rd_addr,
  input  logic [3*PIX_W-1:0] i_rd_data,
  output logic               o_col_valid,
  output logic [3*PIX_W-1:0] o_col_data,
  input  logic               i_res_valid,
  input  logic [RES_W-1:0]   i_res_data,
  output logic               o_res_we,
  output logic [ADDR_W-1:0]  o_res_addr,
  output logic [RES_W-1:0]   o_res_data,
  output logic               o_eop,
  output logic               o_busy,
  output logic               o_rows_ready
);
  import conv_seq_pkg::*;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  len_q, len_d, len_eff;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  col_cnt_q, col_cnt_d;
  logic [ADDR_W-1:0]  res_cnt_q, res_cnt_d;
  logic               load_wr, wrap, rd_en, res_acc;
  logic [1:0]         wr_bank;
  logic               rows_full;
  logic [3*PIX_W-1:0] col_mux;

  logic [2:0]         wr_en_q;
  logic [ADDR_W-1:0]  wr_addr_q, res_addr_q;
  logic [PIX_W-1:0]   wr_data_q;
  logic               rd_vld_q, col_valid_q, res_we_q, eop_q, busy_q, rows_ready_q;
  logic [3*PIX_W-1:0] col_data_q;
  logic [RES_W-1:0]   res_data_q;

  conv_bank_rot #(.PIX_W(PIX_W)) u_rot (
    .i_CLK       (i_CLK),
    .i_rst       (i_rst),
    .wrap_i      (wrap),
    .wr_bank_o   (wr_bank),
    .rows_full_o (rows_full),
    .rd_data_i   (i_rd_data),
    .col_data_o  (col_mux)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_ptr_d  = wr_ptr_q;
    col_cnt_d = col_cnt_q;
    res_cnt_d = res_cnt_q;
    load_wr   = 1'b0;
    wrap      = 1'b0;
    // A fresh row takes its length from the input; mid-row changes are ignored.
    len_eff   = (wr_ptr_q == '0) ? i_img_length : len_q;
    rd_en     = (state_q == S_RUN);
    res_acc   = i_res_valid && (state_q == S_RUN || state_q == S_WAIT_RES) &&
                (res_cnt_q < len_q - ADDR_W'(2));
    if (res_acc) res_cnt_d = res_cnt_q + ADDR_W'(1);

    case (state_q)
      S_IDLE: begin
        if (i_run) begin
          state_d   = rows_full ? S_RUN : S_DONE;
          col_cnt_d = '0;
          res_cnt_d = '0;
        end else if (i_load && i_valid) begin
          load_wr = 1'b1;
          len_d   = len_eff;
          if (wr_ptr_q == len_eff - ADDR_W'(1)) begin
            wrap     = 1'b1;
            wr_ptr_d = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
        end
      end
      S_RUN: begin
        col_cnt_d = col_cnt_q + ADDR_W'(1);
        if (col_cnt_q == len_q - ADDR_W'(1)) state_d = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (res_cnt_d == len_q - ADDR_W'(2)) state_d = S_DONE;
      end
      S_DONE: begin
        if (!i_run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      wr_ptr_q     <= '0;
      col_cnt_q    <= '0;
      res_cnt_q    <= '0;
      wr_en_q      <= 3'b000;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_vld_q     <= 1'b0;
      col_valid_q  <= 1'b0;
      col_data_q   <= '0;
      res_we_q     <= 1'b0;
      res_addr_q   <= '0;
      res_data_q   <= '0;
      eop_q        <= 1'b0;
      busy_q       <= 1'b0;
      rows_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wr_ptr_q     <= wr_ptr_d;
      col_cnt_q    <= col_cnt_d;
      res_cnt_q    <= res_cnt_d;
      wr_en_q      <= load_wr ? (3'b001 << wr_bank) : 3'b000;
      if (load_wr) begin
        wr_addr_q <= wr_ptr_q;
        wr_data_q <= i_pixel;
      end
      rd_vld_q     <= rd_en;
      col_valid_q  <= rd_vld_q;
      if (rd_vld_q) col_data_q <= col_mux;
      res_we_q     <= res_acc;
      if (res_acc) begin
        res_addr_q <= res_cnt_q;
        res_data_q <= i_res_data;
      end
      eop_q        <= (state_q == S_DONE);
      busy_q       <= (state_q != S_IDLE);
      rows_ready_q <= rows_full;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_rd_en      = rd_en;
  assign o_rd_addr    = rd_en ? col_cnt_q : '0;
  assign o_col_valid  = col_valid_q;
  assign o_col_data   = col_data_q;
  assign o_res_we     = res_we_q;
  assign o_res_addr   = res_addr_q;
  assign o_res_data   = res_data_q;
  assign o_eop        = eop_q;
  assign o_busy       = busy_q;
  assign o_rows_ready = rows_ready_q;

endmodule

// File: tb/tb_conv_stripe_sequencer.sv
// tb/tb_conv_stripe_sequencer.sv - scoreboard bench for conv_stripe_sequencer
module tb_conv_stripe_sequencer;
  localparam int ADDR_W = 10;
  localparam int PIX_W  = 8;
  localparam int RES_W  = 13;

  logic               i_CLK;
  logic               i_rst;
  logic [ADDR_W-1:0]  i_img_length;
  logic               i_load, i_run, i_valid;
  logic [PIX_W-1:0]   i_pixel;
  logic [2:0]         o_wr_en;
  logic [ADDR_W-1:0]  o_wr_addr, o_rd_addr, o_res_addr;
  logic [PIX_W-1:0]   o_wr_data;
  logic               o_rd_en, o_col_valid, o_res_we, o_eop, o_busy, o_rows_ready;
  logic [3*PIX_W-1:0] i_rd_data, o_col_data;
  logic               i_res_valid;
  logic [RES_W-1:0]   i_res_data, o_res_data;

  conv_stripe_sequencer #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .RES_W(RES_W)) dut (
    .i_CLK(i_CLK), .i_rst(i_rst), .i_img_length(i_img_length), .i_load(i_load),
    .i_run(i_run), .i_valid(i_valid), .i_pixel(i_pixel), .o_wr_en(o_wr_en),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .i_rd_data(i_rd_data), .o_col_valid(o_col_valid), .o_col_data(o_col_data),
    .i_res_valid(i_res_valid), .i_res_data(i_res_data), .o_res_we(o_res_we),
    .o_res_addr(o_res_addr), .o_res_data(o_res_data), .o_eop(o_eop), .o_busy(o_busy),
    .o_rows_ready(o_rows_ready)
  );

  typedef struct packed { logic [2:0] en; logic [9:0] addr; logic [7:0] data; } wr_t;
  typedef struct packed { logic [9:0] addr; logic [12:0] data; } res_t;

  wr_t         exp_wr[$];
  logic [9:0]  exp_rd[$];
  logic [23:0] exp_col[$];
  res_t        exp_res[$];
  logic [7:0]  mem [0:2][0:1023];

  int   total = 0;
  int   bad   = 0;
  logic mon_en;
  wr_t  ew;
  res_t er;

  initial begin
    i_CLK = 1'b0;
    forever #5 i_CLK = ~i_CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_CLK);
    @(negedge i_CLK);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_a"}, 96'({o_wr_en, o_wr_addr, o_wr_data, o_rd_en, o_rd_addr, o_col_valid, o_col_data}), 96'(0));
    chk({nm, "_b"}, 96'({o_res_we, o_res_addr, o_res_data, o_eop, o_busy}), 96'(0));
    chk({nm, "_rows_ready"}, 96'(o_rows_ready), 96'(0));
  endtask

  task automatic load_row(input int base, input logic [2:0] en);
    wr_t w;
    for (int i = 0; i < 4; i++) begin
      w.en = en; w.addr = 10'(i); w.data = 8'(base + i);
      exp_wr.push_back(w);
      i_load = 1'b1; i_valid = 1'b1; i_pixel = 8'(base + i);
      tick;
    end
    i_valid = 1'b0; i_load = 1'b0;
  endtask

  task automatic run_full(input logic [23:0] c0, input logic [23:0] c1,
                          input logic [23:0] c2, input logic [23:0] c3);
    res_t r;
    int   n;
    for (int i = 0; i < 4; i++) exp_rd.push_back(10'(i));
    exp_col.push_back(c0); exp_col.push_back(c1); exp_col.push_back(c2); exp_col.push_back(c3);
    r.addr = 10'd0; r.data = 13'd100; exp_res.push_back(r);
    r.addr = 10'd1; r.data = 13'd200; exp_res.push_back(r);
    i_run = 1'b1;
    n = 0;
    while (!o_eop && n < 40) begin
      tick;
      n++;
    end
    chk("eop_rise", 96'(o_eop), 96'(1));
    chk("busy_in_done", 96'(o_busy), 96'(1));
    i_run = 1'b0;
    tick; tick; tick;
    chk("eop_fall", 96'(o_eop), 96'(0));
    chk("busy_idle", 96'(o_busy), 96'(0));
    chk("rd_drained", 96'(exp_rd.size()), 96'(0));
    chk("col_drained", 96'(exp_col.size()), 96'(0));
    chk("res_drained", 96'(exp_res.size()), 96'(0));
  endtask

  // Bank memories: one-cycle read latency.
  initial begin : mem_model
    logic       pend;
    logic [9:0] pa;
    i_rd_data = '0;
    forever begin
      @(negedge i_CLK);
      for (int b = 0; b < 3; b++) if (o_wr_en[b]) mem[b][o_wr_addr] = o_wr_data;
      pend = o_rd_en;
      pa   = o_rd_addr;
      @(posedge i_CLK);
      #1;
      if (pend) i_rd_data = {mem[2][pa], mem[1][pa], mem[0][pa]};
    end
  end

  // Convolution unit stand-in: one result per column from the second on (the last is surplus).
  initial begin : conv_model
    int k;
    k = 0;
    i_res_valid = 1'b0;
    i_res_data  = '0;
    forever begin
      @(negedge i_CLK);
      i_res_valid = 1'b0;
      i_res_data  = '0;
      if (!o_busy) k = 0;
      if (o_col_valid) begin
        if (k >= 1) begin
          i_res_valid = 1'b1;
          i_res_data  = 13'(100 * k);
        end
        k++;
      end
    end
  end

  always @(negedge i_CLK) begin
    if (mon_en) begin
      if (o_wr_en != 3'b000) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 96'(o_wr_en), 96'(0));
        else begin
          ew = exp_wr.pop_front();
          chk("wr_en", 96'(o_wr_en), 96'(ew.en));
          chk("wr_addr", 96'(o_wr_addr), 96'(ew.addr));
          chk("wr_data", 96'(o_wr_data), 96'(ew.data));
        end
      end
      if (o_rd_en) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 96'(o_rd_en), 96'(0));
        else chk("rd_addr", 96'(o_rd_addr), 96'(exp_rd.pop_front()));
      end
      if (o_col_valid) begin
        if (exp_col.size() == 0) chk("col_unexpected", 96'(o_col_valid), 96'(0));
        else chk("col_data", 96'(o_col_data), 96'(exp_col.pop_front()));
      end
      if (o_res_we) begin
        if (exp_res.size() == 0) chk("res_unexpected", 96'(o_res_we), 96'(0));
        else begin
          er = exp_res.pop_front();
          chk("res_addr", 96'(o_res_addr), 96'(er.addr));
          chk("res_data", 96'(o_res_data), 96'(er.data));
        end
      end
    end
  end

  initial begin
    mon_en = 1'b0;
    i_rst = 1'b1; i_load = 1'b0; i_valid = 1'b0; i_run = 1'b0;
    i_pixel = '0; i_img_length = '0;
    for (int c = 0; c < 2; c++) begin
      i_load = 1'($urandom); i_valid = 1'($urandom); i_run = 1'($urandom);
      i_pixel = 8'($urandom); i_img_length = 10'($urandom);
      tick;
    end
    chk_zero("reset");
    i_rst = 1'b0; i_load = 1'b0; i_valid = 1'b0; i_run = 1'b0; i_img_length = 10'd4;
    mon_en = 1'b1;
    tick;

    load_row(1, 3'b001);
    load_row(5, 3'b010);
    load_row(9, 3'b100);
    chk("rows_ready_at_last_write", 96'(o_rows_ready), 96'(0));
    tick;
    chk("rows_ready_after", 96'(o_rows_ready), 96'(1));
    run_full(24'h010509, 24'h02060A, 24'h03070B, 24'h04080C);

    load_row(13, 3'b001);
    tick;
    run_full(24'h05090D, 24'h060A0E, 24'h070B0F, 24'h080C10);

    i_rst = 1'b1; tick; tick;
    chk_zero("reset2");
    i_rst = 1'b0; tick;
    load_row(21, 3'b001);
    i_run = 1'b1;
    tick;
    chk("early_eop_t1", 96'(o_eop), 96'(0));
    tick;
    chk("early_eop_t2", 96'(o_eop), 96'(1));
    i_run = 1'b0;
    tick; tick; tick;
    chk("early_eop_fall", 96'(o_eop), 96'(0));

    load_row(31, 3'b010);
    load_row(41, 3'b100);
    tick;
    chk("rows_ready_again", 96'(o_rows_ready), 96'(1));
    for (int i = 0; i < 3; i++) exp_rd.push_back(10'(i));
    exp_col.push_back(24'h151F29);
    i_run = 1'b1;
    tick; tick; tick;
    i_rst = 1'b1; i_run = 1'b0;
    tick;
    chk_zero("midrun_reset");
    i_rst = 1'b0;
    tick;
    chk("midrun_rd_drained", 96'(exp_rd.size()), 96'(0));
    chk("midrun_col_drained", 96'(exp_col.size()), 96'(0));
    i_run = 1'b1;
    tick; tick;
    chk("post_reset_eop", 96'(o_eop), 96'(1));
    i_run = 1'b0;
    tick; tick; tick;
    chk("post_reset_eop_fall", 96'(o_eop), 96'(0));
    chk("wr_drained", 96'(exp_wr.size()), 96'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_stripe_sequencer.md
# conv_stripe_sequencer

Sequences the convolution datapath for one output row. In load mode it steers incoming 8-bit pixels into a rotating set of three row-bank memories. In run mode it streams 3-pixel columns from those banks into the 3x3 convolution unit and writes the 13-bit results into the result buffer. It sits between the GPIO control block, which supplies load/run/valid/image length and receives EOP, and the bank memories, convolution unit and result buffer.

## Interface
Parameters:
- ADDR_W, 10: bank/result address width and image-length width.
- PIX_W, 8: pixel width.
- RES_W, 13: convolution result width.

Ports:
- i_CLK  in  1  clock.
- i_rst  in  1  reset: synchronous, active-high. Clock is i_CLK.
- i_img_length  in  ADDR_W  row length in pixels; legal values are 3..2^ADDR_W-1.
- i_load  in  1  load mode level.
- i_run  in  1  run request level; held until o_eop is seen.
- i_valid  in  1  single-cycle pixel strobe.
- i_pixel  in  PIX_W  pixel data.
- o_wr_en  out  3  one-hot bank write enable.
- o_wr_addr  out  ADDR_W  bank write address.
- o_wr_data  out  PIX_W  bank write data.
- o_rd_en  out  1  bank read strobe, applied to all 3 banks.
- o_rd_addr  out  ADDR_W  bank read address.
- i_rd_data  in  3*PIX_W  read data {bank2,bank1,bank0}; arrives 1 cycle after o_rd_en.
- o_col_valid  out  1  column strobe to the convolution unit.
- o_col_data  out  3*PIX_W  column {top,mid,bottom}; top row is in the MSBs.
- i_res_valid  in  1  result strobe from the convolution unit.
- i_res_data  in  RES_W  convolution result.
- o_res_we, o_res_addr[ADDR_W], o_res_data[RES_W]  out  result buffer write port.
- o_eop  out  1  end of processing.
- o_busy  out  1  state is not IDLE.
- o_rows_ready  out  1  at least 3 complete rows are loaded.

## Operation
- States:
  - IDLE: accepts load writes.
  - RUN: issues reads and collects results.
  - WAIT_RES: all reads issued; still collecting results.
  - DONE: o_eop held high.
- Load, IDLE only:
  - When i_load=1 and i_valid=1: assert o_wr_en = one-hot(wr_bank), o_wr_addr = wr_addr, o_wr_data = i_pixel, all registered.
  - len_q latches i_img_length on each write with wr_addr=0. Mid-row length changes are ignored.
  - wr_addr increments by 1. At len_q-1 it wraps to 0.
  - On wrap: newest <= wr_bank; wr_bank <= (wr_bank+1) mod 3; rows_loaded increments, saturating at 3.
- i_valid is ignored when i_load=0 or the state is not IDLE.
- IDLE transitions:
  - i_run=1 with rows_loaded=3 → RUN. Also clear col_cnt and res_cnt.
  - i_run=1 with rows_loaded<3 → DONE. No reads are issued.
  - i_run has priority over a simultaneous i_load/i_valid; that pixel is dropped.
- RUN:
  - One read per cycle: o_rd_en=1, o_rd_addr=col_cnt, for col_cnt = 0..len_q-1.
  - After the last read, go to WAIT_RES.
- Column ordering: top = (newest+1) mod 3, mid = (newest+2) mod 3, bottom = newest.
- Results:
  - Each i_res_valid in RUN or WAIT_RES while res_cnt < len_q-2 gives o_res_we=1, o_res_addr=res_cnt, o_res_data=i_res_data, then res_cnt increments.
  - Excess results, and results arriving in IDLE or DONE, are dropped.
- WAIT_RES → DONE when res_cnt reaches len_q-2. This can happen in the same cycle as the final write.
- DONE: o_eop=1. When i_run=0 → IDLE. Bank contents and pointers are kept, so the next loaded row replaces the oldest bank.
- Reset, including mid-run:
  - All outputs go to 0.
  - State = IDLE, wr_bank=0, newest=2, wr_addr=0, rows_loaded=0, len_q=0.

## Timing
- Write: i_valid in cycle t → o_wr_en in t+1.
- o_rows_ready rises in the cycle after the third row's last write.
- Read/column: o_rd_en in t → i_rd_data in t+1 → o_col_valid/o_col_data registered in t+2.
- Columns are back-to-back, len_q strobes in total.
- Result write: i_res_valid in t → o_res_we in t+1.
- o_eop: rises the cycle after the state enters DONE and stays high until the cycle after i_run falls. With rows_loaded<3, o_eop rises 2 cycles after i_run.
- o_busy follows the state with 1 cycle of registration.

## Structure
- Package conv_seq_pkg holds:
  - the state encoding;
  - N_BANKS=3, PIX_W, RES_W;
  - the mod-3 increment function.
- Sub-module conv_bank_rot holds:
  - the wr_bank/newest pointers;
  - the rows_loaded saturating counter;
  - the {top,mid,bottom} reorder mux for i_rd_data.
- The FSM, counters and output registers live in the top module.

## Test plan
- Reset: hold i_rst 2 cycles with random inputs → every output is 0, and o_rows_ready=0.
- Load: i_img_length=4, 12 pixels 1..12 → o_wr_en = 001 ×4, 010 ×4, 100 ×4; o_wr_addr cycles 0..3; o_rows_ready=1 one cycle after the 12th write.
- Run:
  - Assert i_run → o_rd_addr 0,1,2,3 on consecutive cycles.
  - o_col_data = 0x010509, 0x02060A, 0x03070B, 0x04080C.
  - The convolution model returns 100 and 200 → res_addr 0,1; o_eop=1.
  - i_run low → o_eop=0, IDLE.
- Rotation: load row 13..16, then run → first o_col_data = 0x05090D; the row-1 bank is overwritten (o_wr_en=001).
- Early run: after reset, load 1 row, then i_run=1 → o_eop high 2 cycles later; o_rd_en never asserts.
- Reset mid-run: i_rst during RUN at col 2 → outputs 0 next cycle, o_rows_ready=0; a subsequent i_run gives immediate EOP.
